// File: rtl/seq_div_pkg.sv
// Shared constants and helpers for the sequential restoring divider.
package seq_div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2, used to size the iteration counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in a bit, trial-subtract, restore on borrow.
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_c,
  output logic             q_bit_c
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Partial remainder stays below the divisor, so the top bit of trial is a clean borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {2'b00, divisor_i};
    q_bit_c = ~trial[WIDTH+1];
    rem_c   = q_bit_c ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_div_unit.sv
// Sequential restoring divider, one quotient bit per clock, start/ready handshake.
// Optional two's-complement mode via SEQ_DIV_SIGNED_EN.
module seq_div_unit
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic [1:0]       state
);

  localparam int unsigned CNT_W = clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
`ifdef SEQ_DIV_SIGNED_EN
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
`endif

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] src_word, step_dvs, qsh_next, quo_fix, rem_fix;
  logic [WIDTH:0]   step_rem_in, step_rem;
  logic             step_q;

  // Operand magnitudes; signs are tracked separately and re-applied on entry to DONE.
  always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
    dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
`endif
  end

  // The accept edge performs the first step straight from the inputs, so RUN needs WIDTH-1 cycles.
  always_comb begin
    if (state_q == ST_RUN) begin
      step_rem_in = rem_q;
      src_word    = qsh_q;
      step_dvs    = dvs_q;
    end else begin
      step_rem_in = '0;
      src_word    = dvd_mag;
      step_dvs    = dvs_mag;
    end
  end

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (step_rem_in),
    .bit_i     (src_word[WIDTH-1]),
    .divisor_i (step_dvs),
    .rem_c     (step_rem),
    .q_bit_c   (step_q)
  );

  always_comb begin
    qsh_next = {src_word[WIDTH-2:0], step_q};
`ifdef SEQ_DIV_SIGNED_EN
    quo_fix = q_neg_q ? (~qsh_next + WIDTH'(1)) : qsh_next;
    rem_fix = r_neg_q ? (~step_rem[WIDTH-1:0] + WIDTH'(1)) : step_rem[WIDTH-1:0];
`else
    quo_fix = qsh_next;
    rem_fix = step_rem[WIDTH-1:0];
`endif
  end

  // Next-state and result update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    qsh_d       = qsh_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
`ifdef SEQ_DIV_SIGNED_EN
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(WIDTH - 2);
            rem_d   = step_rem;
            qsh_d   = qsh_next;
            dvs_d   = dvs_mag;
`ifdef SEQ_DIV_SIGNED_EN
            q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_d = dividend[WIDTH-1];
`endif
          end
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        qsh_d = qsh_next;
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          quotient_d  = quo_fix;
          remainder_d = rem_fix;
          div_zero_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      qsh_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      qsh_q       <= qsh_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
`ifdef SEQ_DIV_SIGNED_EN
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign state     = state_q;

endmodule
